// File: rtl/neuron_step_sequencer.sv
// Step sequencer for a bank of neuron cores: strobes the enabled cores, waits for them
// to go idle, then streams the captured spike flags out as indexed events.
//
// state | meaning
// IDLE  | waiting for step_start / reset_all
// ISSUE | one-cycle update or reset strobe to the latched mask
// ARM   | settle cycle, cores raise busy one cycle after the strobe
// WAIT  | wait for masked cores idle, or give up after TIMEOUT cycles
// SCAN  | walk spike vector, emit one event per set bit
// DONE  | publish spike_count, pulse step_done
module neuron_step_sequencer #(
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = 3,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_start,
    input  logic                   reset_all,
    input  logic [NUM_NEURONS-1:0] enable_mask,
    output logic [NUM_NEURONS-1:0] core_start_update,
    output logic [NUM_NEURONS-1:0] core_start_reset,
    input  logic [NUM_NEURONS-1:0] core_busy,
    input  logic [NUM_NEURONS-1:0] core_spike,
    output logic                   spike_valid,
    input  logic                   spike_ready,
    output logic [IDX_W-1:0]       spike_id,
    output logic [IDX_W:0]         spike_count,
    output logic                   step_done,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   step_overrun
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, SCAN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [NUM_NEURONS-1:0] mask_q;
    logic [NUM_NEURONS-1:0] spk_vec;
    logic                   cmd_is_reset;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W:0]         run_cnt;
    logic [IDX_W:0]         spike_count_q;
    logic                   all_idle;
    logic                   tmo_hit;
    logic                   cur_spk;
    logic                   idx_last;

    assign all_idle = (core_busy & mask_q) == '0;
    assign tmo_hit  = tmo_cnt == CNT_W'(TIMEOUT - 1);
    assign cur_spk  = spk_vec[idx];
    assign idx_last = idx == IDX_W'(NUM_NEURONS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mask_q        <= '0;
            spk_vec       <= '0;
            cmd_is_reset  <= 1'b0;
            tmo_cnt       <= '0;
            idx           <= '0;
            run_cnt       <= '0;
            spike_count_q <= '0;
            timeout_err   <= 1'b0;
            step_overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != IDLE && (step_start || reset_all))
                step_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    // reset_all takes priority over a simultaneous step_start
                    if (reset_all) begin
                        mask_q       <= enable_mask;
                        cmd_is_reset <= 1'b1;
                    end else if (step_start) begin
                        mask_q       <= enable_mask;
                        cmd_is_reset <= 1'b0;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    idx     <= '0;
                end
                WAIT: begin
                    if (all_idle) begin
                        spk_vec <= core_spike & mask_q;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        spk_vec     <= core_spike & mask_q & ~core_busy;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (cur_spk && spike_ready)
                        run_cnt <= run_cnt + 1'b1;
                    if (!cur_spk || spike_ready)
                        idx <= idx + 1'b1;
                end
                DONE: begin
                    spike_count_q <= run_cnt;
                    run_cnt       <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt         = state;
        core_start_update = '0;
        core_start_reset  = '0;
        spike_valid       = 1'b0;
        step_done         = 1'b0;
        case (state)
            IDLE:  if (reset_all || step_start) state_nxt = ISSUE;
            ISSUE: begin
                if (cmd_is_reset) core_start_reset  = mask_q;
                else              core_start_update = mask_q;
                state_nxt = ARM;
            end
            ARM:   state_nxt = WAIT;
            WAIT:  if (all_idle || tmo_hit) state_nxt = cmd_is_reset ? IDLE : SCAN;
            SCAN: begin
                spike_valid = cur_spk;
                if ((!cur_spk || spike_ready) && idx_last) state_nxt = DONE;
            end
            DONE: begin
                step_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign spike_id    = spike_valid ? idx : '0;
    assign spike_count = (state == DONE) ? run_cnt : spike_count_q;
    assign busy        = state != IDLE;
endmodule

// File: tb/tb_neuron_step_sequencer.sv
// Bench for neuron_step_sequencer: ideal core model, event scoreboard, table of
// mask/spike vectors plus hand-written stall, timeout, reset-command and rst sequences.
module tb_neuron_step_sequencer;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step_start = 1'b0;
    logic          reset_all = 1'b0;
    logic          spike_ready = 1'b1;
    logic [N-1:0]  enable_mask = '0;
    logic [N-1:0]  core_spike = '0;
    logic [N-1:0]  hang = '0;
    logic [N-1:0]  core_busy_r;
    logic [N-1:0]  core_busy;
    logic [N-1:0]  core_start_update;
    logic [N-1:0]  core_start_reset;
    logic          spike_valid;
    logic [IW-1:0] spike_id;
    logic [IW:0]   spike_count;
    logic          step_done;
    logic          busy;
    logic          timeout_err;
    logic          step_overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_q[$];

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] spike;
        int           exp_cnt;
    } vec_t;
    vec_t vecs[5];

    neuron_step_sequencer #(.NUM_NEURONS(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .step_start(step_start), .reset_all(reset_all),
        .enable_mask(enable_mask), .core_start_update(core_start_update),
        .core_start_reset(core_start_reset), .core_busy(core_busy),
        .core_spike(core_spike), .spike_valid(spike_valid), .spike_ready(spike_ready),
        .spike_id(spike_id), .spike_count(spike_count), .step_done(step_done),
        .busy(busy), .timeout_err(timeout_err), .step_overrun(step_overrun)
    );

    always #5 clk = ~clk;

    // ideal cores: busy for exactly the cycle after their strobe; hang forces busy
    always_ff @(posedge clk) begin
        if (rst) core_busy_r <= '0;
        else     core_busy_r <= core_start_update | core_start_reset;
    end
    assign core_busy = core_busy_r | hang;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk) begin
        if (!rst && spike_valid && spike_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_event: got spike_id %0d expected no event", spike_id);
            end else begin
                check("event_id", int'(spike_id), exp_q.pop_front());
            end
        end
    end

    // drives a step in cycle T, returns at the negedge of T+1
    task automatic start_step(input logic [N-1:0] m, input logic [N-1:0] s);
        @(negedge clk);
        enable_mask = m;
        core_spike  = s;
        step_start  = 1'b1;
        for (int i = 0; i < N; i++)
            if (m[i] && s[i] && !hang[i]) exp_q.push_back(i);
        @(negedge clk);
        step_start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n, output bit ok);
        n  = n0;
        ok = 1'b0;
        while (!ok && n < 60) begin
            @(negedge clk);
            n++;
            if (step_done) ok = 1'b1;
        end
        check("step_done_seen", int'(ok), 1);
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (spike_valid) seen = 1'b1;
        end
        check("valid_seen", int'(seen), 1);
    endtask

    initial begin
        int n;
        bit ok;
        bit seen_done;

        vecs[0] = '{4'b1111, 4'b1010, 2};
        vecs[1] = '{4'b0110, 4'b1111, 2};
        vecs[2] = '{4'b1111, 4'b1111, 4};
        vecs[3] = '{4'b1111, 4'b0000, 0};
        vecs[4] = '{4'b0000, 4'b1111, 0};

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(spike_valid), 0);
        check("rst_done", int'(step_done), 0);
        check("rst_count", int'(spike_count), 0);
        check("rst_timeout", int'(timeout_err), 0);
        check("rst_overrun", int'(step_overrun), 0);
        check("rst_update", int'(core_start_update), 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            start_step(vecs[v].mask, vecs[v].spike);
            check($sformatf("v%0d_update", v), int'(core_start_update), int'(vecs[v].mask));
            check($sformatf("v%0d_reset_strobe", v), int'(core_start_reset), 0);
            check($sformatf("v%0d_busy", v), int'(busy), 1);
            @(negedge clk);
            check($sformatf("v%0d_strobe_one_cycle", v), int'(core_start_update), 0);
            wait_done(2, n, ok);
            check($sformatf("v%0d_done_cycle", v), n, 8);
            @(negedge clk);
            check($sformatf("v%0d_count", v), int'(spike_count), vecs[v].exp_cnt);
            check($sformatf("v%0d_idle", v), int'(busy), 0);
            check($sformatf("v%0d_q_empty", v), exp_q.size(), 0);
        end

        // downstream stall on id 0
        spike_ready = 1'b0;
        start_step(4'b1111, 4'b0001);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", int'(spike_valid), 1);
            check("stall_id", int'(spike_id), 0);
            @(negedge clk);
        end
        spike_ready = 1'b1;
        wait_done(0, n, ok);
        @(negedge clk);
        check("stall_count", int'(spike_count), 1);
        check("stall_q_empty", exp_q.size(), 0);

        // hung core 2
        hang = 4'b0100;
        start_step(4'b1111, 4'b1111);
        wait_done(1, n, ok);
        check("tmo_done_cycle", n, 15);
        @(negedge clk);
        check("tmo_count", int'(spike_count), 3);
        check("tmo_err", int'(timeout_err), 1);
        check("tmo_q_empty", exp_q.size(), 0);
        hang = '0;
        start_step(4'b1111, 4'b0001);
        wait_done(1, n, ok);
        @(negedge clk);
        check("tmo_sticky", int'(timeout_err), 1);
        check("after_tmo_count", int'(spike_count), 1);

        // reset_all + step_start together, then a step_start while busy
        check("overrun_clear", int'(step_overrun), 0);
        @(negedge clk);
        enable_mask = 4'b1011;
        reset_all   = 1'b1;
        step_start  = 1'b1;
        @(negedge clk);
        reset_all  = 1'b0;
        step_start = 1'b0;
        seen_done  = step_done;
        check("rcmd_reset_strobe", int'(core_start_reset), 4'b1011);
        check("rcmd_update_strobe", int'(core_start_update), 0);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            step_start = (k == 2);
            if (step_done) seen_done = 1'b1;
            if (k == 4) check("rcmd_idle_t4", int'(busy), 0);
        end
        step_start = 1'b0;
        check("rcmd_no_done", int'(seen_done), 0);
        check("rcmd_overrun", int'(step_overrun), 1);
        check("rcmd_idle_end", int'(busy), 0);

        // rst during SCAN with a stalled event
        spike_ready = 1'b0;
        start_step(4'b1111, 4'b0001);
        wait_valid();
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("mrst_valid", int'(spike_valid), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_count", int'(spike_count), 0);
        check("mrst_timeout", int'(timeout_err), 0);
        check("mrst_overrun", int'(step_overrun), 0);
        check("mrst_id", int'(spike_id), 0);
        rst = 1'b0;
        spike_ready = 1'b1;
        start_step(4'b1111, 4'b0110);
        wait_done(1, n, ok);
        check("post_rst_done_cycle", n, 8);
        @(negedge clk);
        check("post_rst_count", int'(spike_count), 2);
        check("post_rst_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end
endmodule
